// File: rtl/riscv_enc_pkg.sv
// Shared types for the instruction encoder/loader: field widths, immediate formats, FSM states.
package riscv_enc_pkg;

    localparam int XLEN  = 32;
    localparam int OPC_W = 7;
    localparam int REG_W = 5;
    localparam int F3_W  = 3;
    localparam int F7_W  = 7;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_src_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    typedef struct packed {
        logic              has_imm;
        imm_src_e          imm_src;
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  rd;
        logic [F3_W-1:0]   funct3;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [F7_W-1:0]   funct7;
        logic [XLEN-1:0]   imm;
    } fields_t;

    // True when imm[XLEN-1:msb] are all equal, i.e. the value survives truncation to msb+1 signed bits.
    function automatic logic imm_fits(input logic [XLEN-1:0] imm, input int msb);
        logic [XLEN-1:0] mask;
        mask = {XLEN{1'b1}} << msb;
        return ((imm & mask) == mask) || ((imm & mask) == '0);
    endfunction

endpackage

// File: rtl/instr_packer.sv
// Packs instruction fields plus immediate into an RV32 word and flags unrepresentable immediates.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module instr_packer
    import riscv_enc_pkg::*;
(
    input  fields_t          i_fields,
    output logic [XLEN-1:0]  o_word,
    output logic             o_range_err
);

    logic [XLEN-1:0] w_imm;
    assign w_imm = i_fields.imm;

    always_comb begin
        o_word      = '0;
        o_range_err = 1'b0;
        if (!i_fields.has_imm) begin
            o_word = {i_fields.funct7, i_fields.rs2, i_fields.rs1, i_fields.funct3,
                      i_fields.rd, i_fields.opcode};
        end else begin
            case (i_fields.imm_src)
                IMM_I: begin
                    o_word      = {w_imm[11:0], i_fields.rs1, i_fields.funct3, i_fields.rd,
                                   i_fields.opcode};
                    o_range_err = !imm_fits(w_imm, 11);
                end
                IMM_S: begin
                    o_word      = {w_imm[11:5], i_fields.rs2, i_fields.rs1, i_fields.funct3,
                                   w_imm[4:0], i_fields.opcode};
                    o_range_err = !imm_fits(w_imm, 11);
                end
                // Branch and jump offsets are halfword multiples; bit 0 is dropped by the encoding.
                IMM_B: begin
                    o_word      = {w_imm[12], w_imm[10:5], i_fields.rs2, i_fields.rs1,
                                   i_fields.funct3, w_imm[4:1], w_imm[11], i_fields.opcode};
                    o_range_err = !imm_fits(w_imm, 12) || w_imm[0];
                end
                IMM_J: begin
                    o_word      = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                                   i_fields.rd, i_fields.opcode};
                    o_range_err = !imm_fits(w_imm, 20) || w_imm[0];
                end
                default: begin
                    o_word      = '0;
                    o_range_err = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes a stream of instruction beats and writes them into imem from base_addr upward.
// Latency: one cycle from accepted beat to imem write; done coincides with the final write.
// Backpressure: in_ready high only while loading and below IMEM_DEPTH words.
module instr_encoder_loader
    import riscv_enc_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int CNT_W      = $clog2(IMEM_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic              has_imm,
    input  logic [1:0]        imm_src,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_range,
    output logic              err_ovf,
    output logic              err_align,
    output logic [CNT_W-1:0]  count
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_inc;
    logic [31:0]       r_base;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_err_range;
    logic              r_err_ovf;
    logic              r_err_align;
    fields_t           w_fields;
    logic [31:0]       w_word;
    logic              w_range_err;
    logic              w_start_acc;
    logic              w_accept;
    logic              w_misaligned;
    logic              w_full_nxt;

    always_comb begin
        w_fields         = '0;
        w_fields.has_imm = has_imm;
        w_fields.imm_src = imm_src_e'(imm_src);
        w_fields.opcode  = opcode;
        w_fields.rd      = rd;
        w_fields.funct3  = funct3;
        w_fields.rs1     = rs1;
        w_fields.rs2     = rs2;
        w_fields.funct7  = funct7;
        w_fields.imm     = imm;
    end

    instr_packer u_packer (
        .i_fields    (w_fields),
        .o_word      (w_word),
        .o_range_err (w_range_err)
    );

    assign w_start_acc  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_accept     = in_valid && in_ready;
    assign w_misaligned = (base_addr[1:0] != 2'b00);
    assign w_count_inc  = r_count + 1'b1;
    assign w_full_nxt   = (w_count_inc == CNT_W'(IMEM_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start_acc) w_state_nxt = w_misaligned ? DONE : LOAD;
            LOAD: if (w_accept && (in_last || w_full_nxt)) w_state_nxt = DONE;
            DONE: begin
                if (w_start_acc) w_state_nxt = w_misaligned ? DONE : LOAD;
                else             w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == LOAD) && (r_count < CNT_W'(IMEM_DEPTH));
        busy     = (r_state == LOAD);
        done     = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_base      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_err_range <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_align <= 1'b0;
        end else begin
            r_we <= w_accept;
            if (w_start_acc) begin
                r_base      <= base_addr;
                r_count     <= '0;
                r_err_range <= 1'b0;
                r_err_ovf   <= 1'b0;
                r_err_align <= w_misaligned;
            end else if (w_accept) begin
                r_addr  <= r_base + (32'(r_count) << 2);
                r_wdata <= w_word;
                r_count <= w_count_inc;
                if (w_range_err)            r_err_range <= 1'b1;
                if (!in_last && w_full_nxt) r_err_ovf   <= 1'b1;
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign err_range  = r_err_range;
    assign err_ovf    = r_err_ovf;
    assign err_align  = r_err_align;
    assign count      = r_count;

endmodule
